apb_req_master: RTL

- APB3 initiator that converts a simple request/grant/response core-side interface into APB SETUP/ACCESS transfers.
- Drives the peripheral-side APB bus that event/interrupt/sleep-style slaves hang off.
- Used by debug/DMA-style agents that need register access to APB peripherals without owning APB timing.
- One outstanding transfer at a time; back-to-back transfers supported with no idle cycle.

---
 rtl/apb_master_pkg.sv | 13 +
 rtl/apb_mst_timeout_cnt.sv | 37 +++
 rtl/apb_req_master.sv | 137 +++++++++++++
 3 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB request master.
// The optional timeout feature is enabled with APB_REQ_MASTER_TIMEOUT_EN.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_t;

    localparam int unsigned APB_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/apb_mst_timeout_cnt.sv
// ACCESS-phase wait-state counter; only instantiated when APB_REQ_MASTER_TIMEOUT_EN is defined.
// expire_o flags the last permitted wait cycle so the master can abort on the following edge.
module apb_mst_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = apb_master_pkg::APB_TIMEOUT_DEFAULT
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_req_master.sv
// APB3 initiator: turns a req/gnt/resp core interface into SETUP/ACCESS transfers.
// Define APB_REQ_MASTER_TIMEOUT_EN to abort ACCESS phases that wait too long for PREADY.
module apb_req_master
    import apb_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_we_i,
    input  logic [31:0]               req_wdata_i,
    output logic                      gnt_o,
    output logic                      resp_valid_o,
    output logic [31:0]               resp_rdata_o,
    output logic                      resp_err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    apb_mst_state_t            state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      resp_valid_q, resp_valid_d;
    logic [31:0]               resp_rdata_q, resp_rdata_d;
    logic                      resp_err_q, resp_err_d;

    logic xfer_done;
    logic timeout_expire;

    assign xfer_done = (state_q == ACCESS) && PREADY;
    assign gnt_o     = req_i && ((state_q == IDLE) || xfer_done);

`ifdef APB_REQ_MASTER_TIMEOUT_EN
    apb_mst_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .clr_i    (state_q == SETUP),
        .en_i     ((state_q == ACCESS) && !PREADY),
        .expire_o (timeout_expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_expire     = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (gnt_o) state_d = SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_d = req_i ? SETUP : IDLE;
                end else if (timeout_expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus control strobes follow the state directly, so reset drops them asynchronously.
    always_comb begin
        PSEL    = (state_q == SETUP) || (state_q == ACCESS);
        PENABLE = (state_q == ACCESS);
    end

    // Request capture and response formation.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        if (gnt_o) begin
            paddr_d  = req_addr_i;
            pwrite_d = req_we_i;
            pwdata_d = req_we_i ? req_wdata_i : 32'h0;
        end

        if (xfer_done) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = pwrite_q ? 32'h0 : PRDATA;
            resp_err_d   = PSLVERR;
        end else if (timeout_expire) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
            resp_err_d   = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!HRESETn) begin
            state_q      <= IDLE;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pwrite_q     <= pwrite_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign PADDR        = paddr_q;
    assign PWDATA       = pwdata_q;
    assign PWRITE       = pwrite_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule
